ysyx_220066_divider: RTL and testbench



---
 rtl/ysyx_220066_divider.sv | 209 ++++++++++++++++++++
 tb/tb_ysyx_220066_divider.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220066_divider.sv
// ---------------------------------------------------------------------------
// ysyx_220066_divider
//
// Multi-cycle RV64M divide/remainder unit (DIV, DIVU, REM, REMU and their W
// forms) placed next to the single-cycle ALU in EX. Radix-2 restoring core,
// valid/ready handshake on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous abort of whatever is in flight
//   in_valid   request valid
//   in_ready   unit idle and able to accept a request
//   dividend   rs1
//   divisor    rs2
//   is_signed  1: DIV/REM(W), 0: unsigned forms
//   is_rem     1: return remainder, 0: return quotient
//   is_word    1: 32-bit operation, result sign-extended from bit 31
//   out_valid  result valid (registered, state == DONE)
//   out_ready  consumer takes the result
//   result     quotient or remainder (registered)
//
// Timing: the acceptance edge already performs the first restoring step
// (the partial remainder is zero at that point, so the step is just the
// dividend MSB against the divisor). The remaining N-1 steps run in CALC,
// one more cycle fixes signs, so out_valid is seen N+1 cycles after the
// acceptance edge (cycle 1 = the cycle right after it). Divide-by-zero and
// signed overflow bypass the core and are seen in cycle 1.
// ---------------------------------------------------------------------------
module ysyx_220066_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic            is_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int WLEN = 32;
  // Steps left for CALC after the one folded into the acceptance edge.
  localparam logic [5:0] FULL_STEPS = 6'(XLEN - 1);
  localparam logic [5:0] WORD_STEPS = 6'(WLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [XLEN-1:0] rem_reg;      // partial remainder
  logic [XLEN-1:0] quot_reg;     // dividend bits shifting out, quotient bits shifting in
  logic [XLEN-1:0] div_reg;      // |divisor|
  logic [XLEN-1:0] result_reg;
  logic [5:0]      count_reg;    // CALC steps still to do
  logic            qneg_reg;
  logic            rneg_reg;
  logic            sel_rem_reg;
  logic            word_reg;

  // Sign-extend bit 31 for word ops (also for DIVUW/REMUW).
  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v,
                                                input logic            word);
    return word ? {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]} : v;
  endfunction

  // One restoring step: shift {rem,quot} left, trial-subtract the divisor.
  // The quotient bit is the inverted borrow; on borrow the shifted value is
  // kept (restore). The subtraction only needs XLEN bits: when it fits, the
  // true difference is below the divisor.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quot,
                                                 input logic [XLEN-1:0] d);
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] diff;
    shifted = {rem, quot[XLEN-1]};
    fits    = (shifted >= {1'b0, d});
    diff    = shifted[XLEN-1:0] - d;
    return {(fits ? diff : shifted[XLEN-1:0]), quot[XLEN-2:0], fits};
  endfunction

  // ------------------------------------------------------------------
  // Operand preparation (evaluated for the request on the inputs)
  // ------------------------------------------------------------------
  logic [XLEN-1:0] a_eff, b_eff, a_abs, b_abs, a_min;
  logic [XLEN-1:0] quot_init, special_raw, special_res;
  logic            a_neg, b_neg, div_zero, overflow, special, accept;

  always_comb begin
    a_eff = dividend;
    b_eff = divisor;
    if (is_word) begin
      a_eff = is_signed ? {{(XLEN-WLEN){dividend[WLEN-1]}}, dividend[WLEN-1:0]}
                        : {{(XLEN-WLEN){1'b0}}, dividend[WLEN-1:0]};
      b_eff = is_signed ? {{(XLEN-WLEN){divisor[WLEN-1]}}, divisor[WLEN-1:0]}
                        : {{(XLEN-WLEN){1'b0}}, divisor[WLEN-1:0]};
    end

    a_neg = is_signed & a_eff[XLEN-1];
    b_neg = is_signed & b_eff[XLEN-1];
    a_abs = a_neg ? (~a_eff + 1'b1) : a_eff;
    b_abs = b_neg ? (~b_eff + 1'b1) : b_eff;

    // Most negative value of the effective width, as a 64-bit pattern.
    a_min = is_word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                    : {1'b1, {(XLEN-1){1'b0}}};

    div_zero = (b_eff == '0);
    overflow = is_signed & (a_eff == a_min) & (b_eff == '1);
    special  = div_zero | overflow;

    if (div_zero) special_raw = is_rem ? a_eff : '1;
    else          special_raw = is_rem ? '0    : a_eff;
    special_res = sext_word(special_raw, is_word);

    // Word dividends sit in the upper half so that exactly 32 steps leave
    // the quotient in the low half and zeros above it.
    quot_init = is_word ? {a_abs[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : a_abs;
  end

  logic [2*XLEN-1:0] first_step, calc_step;
  logic [XLEN-1:0]   q_fix, r_fix;

  assign first_step = div_step('0, quot_init, b_abs);
  assign calc_step  = div_step(rem_reg, quot_reg, div_reg);

  assign q_fix = qneg_reg ? (~quot_reg + 1'b1) : quot_reg;
  assign r_fix = (rneg_reg && (rem_reg != '0)) ? (~rem_reg + 1'b1) : rem_reg;

  // in_ready is also held low while rst is asserted.
  assign in_ready  = (state_reg == IDLE) & ~flush & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: if (count_reg == 6'd1) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort wins over everything, including a DONE handshake.
    if (flush) state_next = IDLE;
  end

  // ------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg     <= '0;
      quot_reg    <= '0;
      div_reg     <= '0;
      result_reg  <= '0;
      count_reg   <= '0;
      qneg_reg    <= 1'b0;
      rneg_reg    <= 1'b0;
      sel_rem_reg <= 1'b0;
      word_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            qneg_reg              <= a_neg ^ b_neg;
            rneg_reg              <= a_neg;
            sel_rem_reg           <= is_rem;
            word_reg              <= is_word;
            div_reg               <= b_abs;
            count_reg             <= is_word ? WORD_STEPS : FULL_STEPS;
            {rem_reg, quot_reg}   <= first_step;
            if (special) result_reg <= special_res;
          end
        end
        CALC: begin
          {rem_reg, quot_reg} <= calc_step;
          count_reg           <= count_reg - 6'd1;
        end
        FIX: begin
          result_reg <= sext_word(sel_rem_reg ? r_fix : q_fix, word_reg);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_220066_divider.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_220066_divider.
// A driver issues requests and pushes the expected result and latency into a
// scoreboard queue; a monitor on the falling edge pops and compares at every
// delivered result. Directed cases use literal expectations, random cases use
// an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_ysyx_220066_divider;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic        is_signed, is_rem, is_word;
  logic        out_valid, out_ready;
  logic        man_ready, rnd_ready, bp_mode;
  logic [63:0] dividend, divisor, result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];

  ysyx_220066_divider #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .is_rem    (is_rem),
    .is_word   (is_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end
  assign out_ready = bp_mode ? rnd_ready : man_ready;

  initial begin
    #800000;
    $display("FAIL watchdog: time=%0t limit reached", $time);
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model (RISC-V M semantics) ----------------
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input logic r, input logic w);
    logic [31:0] ua, ub, r32;
    int          sa, sb;
    longint      la, lb;
    logic [63:0] r64;
    if (w) begin
      ua = a[31:0]; ub = b[31:0]; sa = a[31:0]; sb = b[31:0];
      if (ub == 32'd0)                                  r32 = r ? ua : 32'hFFFF_FFFF;
      else if (s && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = r ? 32'd0 : ua;
      else if (s)                                       r32 = r ? sa % sb : sa / sb;
      else                                              r32 = r ? ua % ub : ua / ub;
      return {{32{r32[31]}}, r32};
    end
    la = a; lb = b;
    if (b == 64'd0)                                           r64 = r ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r64 = r ? 64'd0 : a;
    else if (s)                                               r64 = r ? la % lb : la / lb;
    else                                                      r64 = r ? a % b : a / b;
    return r64;
  endfunction

  function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic w);
    logic [63:0] ae, be;
    ae = w ? (s ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
    be = w ? (s ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
    if (be == 64'd0) return 1;
    if (s && be == 64'hFFFF_FFFF_FFFF_FFFF &&
        ae == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 1;
    return w ? 33 : 65;
  endfunction

  // ---------------- monitor ----------------
  logic        prev_valid = 1'b0;
  logic [63:0] held;
  int          first_cyc;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        first_cyc = cyc;
        held      = result;
      end else if (out_valid) begin
        check("result_stable", result, held);
      end
      if (out_valid) check("in_ready_while_done", 64'(in_ready), 64'd0);
      if (out_valid && out_ready && !flush) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got=%h expected=no output", result);
        end else begin
          mon_e = sb_q.pop_front();
          check("result", result, mon_e.res);
          check("latency", 64'(first_cyc - mon_e.acc + 1), 64'(mon_e.lat));
          $display("txn acc_cycle=%0d result=%h expected=%h latency=%0d expected_latency=%0d",
                   mon_e.acc, result, mon_e.res, first_cyc - mon_e.acc + 1, mon_e.lat);
        end
      end
      prev_valid = out_valid;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_exp(input logic [63:0] a, input logic [63:0] b, input logic s,
                           input logic r, input logic w, input logic [63:0] er, input int el);
    exp_t e;
    int   g;
    g = 0;
    while (!in_ready && g < 300) begin
      tick();
      g++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=%b expected=1", in_ready);
      return;
    end
    dividend = a; divisor = b; is_signed = s; is_rem = r; is_word = w;
    in_valid = 1'b1;
    e.res = er; e.lat = el; e.acc = cyc + 1;
    sb_q.push_back(e);
    tick();
    in_valid = 1'b0;
    // Scramble inputs after acceptance: the unit must have latched them.
    dividend  = {$urandom, $urandom};
    divisor   = {$urandom, $urandom};
    is_signed = ~s; is_rem = ~r; is_word = ~w;
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic r, input logic w);
    issue_exp(a, b, s, r, w, ref_div(a, b, s, r, w), ref_lat(a, b, s, w));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 300) begin
      tick();
      g++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending=%0d expected=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!out_valid && g < 200) begin
      tick();
      g++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout: out_valid=%b expected=1", out_valid);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] a, b;
    logic        s, r, w;
    int          cls;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    dividend = '0; divisor = '0; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
    man_ready = 1'b1; bp_mode = 1'b0;

    tick(); tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result",    result,         64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd0);
    #3 rst = 1'b0;
    tick();
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Directed cases with literal expectations.
    issue_exp(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65); drain();
    issue_exp(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 65); drain();
    issue_exp(64'h1234, 64'd0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1); drain();
    issue_exp(64'h1234, 64'd0, 0, 1, 0, 64'h1234, 1); drain();
    issue_exp(64'h0000_0000_8000_0005, 64'd0, 1, 1, 1, 64'hFFFF_FFFF_8000_0005, 1); drain();
    issue_exp(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 0, 1, 64'hFFFF_FFFF_8000_0000, 1); drain();
    issue_exp(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 64'd0, 1); drain();
    issue_exp(64'h0000_0000_FFFF_FFFF, 64'd1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 33); drain();
    issue_exp(64'd100, 64'd7, 0, 1, 1, 64'd2, 33); drain();

    // Backpressure, then a back-to-back request.
    man_ready = 1'b0;
    issue_exp(64'd1000, 64'd7, 0, 0, 0, 64'd142, 65);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_result",   result,        64'd142);
    end
    man_ready = 1'b1;
    tick();
    check("in_ready_after_handshake", 64'(in_ready), 64'd1);
    issue_exp(64'd100, 64'd7, 0, 1, 1, 64'd2, 33);
    drain();

    // flush together with in_valid: not accepted.
    dividend = 64'd100; divisor = 64'd7; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    #1;
    check("flush_blocks_accept", 64'(in_ready), 64'd1);

    // flush in the 10th CALC cycle.
    issue(64'hFFFF_FFFF_FFFF_0000, 64'd3, 0, 0, 0);
    repeat (9) tick();
    flush = 1'b1;
    sb_q.delete();
    tick();
    flush = 1'b0;
    #1;
    check("flush_calc_out_valid", 64'(out_valid), 64'd0);
    check("flush_calc_in_ready",  64'(in_ready),  64'd1);
    issue_exp(64'd10, 64'd3, 0, 0, 0, 64'd3, 65);
    drain();

    // flush in DONE together with out_ready: result not delivered.
    man_ready = 1'b0;
    issue_exp(64'h1234, 64'd0, 0, 1, 0, 64'h1234, 1);
    wait_valid();
    man_ready = 1'b1; flush = 1'b1;
    sb_q.delete();
    tick();
    flush = 1'b0;
    #1;
    check("flush_done_out_valid", 64'(out_valid), 64'd0);
    check("flush_done_in_ready",  64'(in_ready),  64'd1);

    // Asynchronous reset in the middle of CALC.
    issue(64'd123456789, 64'd1000, 0, 0, 0);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_async_out_valid", 64'(out_valid), 64'd0);
    check("rst_async_in_ready",  64'(in_ready),  64'd0);
    sb_q.delete();
    tick(); tick();
    #2 rst = 1'b0;
    tick();
    check("rst_release_in_ready",  64'(in_ready),  64'd1);
    check("rst_release_out_valid", 64'(out_valid), 64'd0);

    // Randomized traffic with random backpressure.
    bp_mode = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cls = $urandom_range(0, 4);
      s = 1'($urandom); r = 1'($urandom); w = 1'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case (cls)
        1: begin
          a = 64'($urandom_range(0, 100000));
          b = 64'($urandom_range(1, 50));
          if ($urandom_range(0, 1) == 1) b = ~b + 64'd1;
        end
        2: b = w ? {$urandom, 32'd0} : 64'd0;
        3: begin
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        4: b = {32'd0, 32'($urandom_range(1, 9))};
        default: ;
      endcase
      issue(a, b, s, r, w);
    end
    drain();
    bp_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
